// File: rtl/ins_mem_loader_pkg.sv
// ins_mem_loader_pkg
//   Shared definitions for the instruction-memory write path.
//   Holds the byte/word geometry, the InsMemRW level constants and the
//   loader state encoding. The instruction memory uses the same constants,
//   so both sides agree on which level means "write".
//   No ports (package).

package ins_mem_loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = 4;

  // InsMemRW levels: read is the idle level, write is a one-cycle strobe
  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/ins_word_packer.sv
// ins_word_packer
//   Packs a byte stream big-endian into 32-bit words. The first byte of a
//   word ends up in bits [31:24] because every new byte shifts in from the
//   bottom.
// Ports
//   clk       in   1       clock
//   rst       in   1       asynchronous active-high reset
//   clear     in   1       restart the byte count at a word boundary
//   shift_en  in   1       a byte is accepted this cycle
//   byte_in   in   8       byte to shift in
//   word      out  32      packed word (valid once word_full has fired)
//   word_full out  1       the byte accepted this cycle completes a word

module ins_word_packer
  import ins_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [1:0] byte_cnt;

  // The 2-bit counter wraps to 0 on the 4th byte, so no explicit clear
  // is needed between words of the same load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word     <= '0;
      byte_cnt <= 2'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
    end else if (shift_en) begin
      word     <= {word[WORD_W-BYTE_W-1:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign word_full = shift_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/ins_mem_loader.sv
// ins_mem_loader
//   Write-side companion of the instruction memory. Accepts bytes over a
//   valid/ready handshake, packs four of them into one instruction and
//   writes it at consecutive word addresses starting at BASE_ADDR, pulsing
//   InsMemRW low for exactly one cycle per word.
// Ports
//   CLK           in   1      clock
//   Reset         in   1      asynchronous active-high reset
//   start         in   1      begin a load (only looked at in IDLE)
//   len_words     in   CNT_W  number of words to load, sampled with start
//   byte_valid    in   1      source presents byte_data
//   byte_data     in   8      next byte, first byte of a word is [31:24]
//   byte_ready    out  1      loader accepts a byte this cycle
//   IAddr         out  32     byte address to instruction memory
//   IDataIn       out  32     instruction word to write
//   InsMemRW      out  1      0 = write this cycle, 1 = read (idle)
//   busy          out  1      load in progress
//   done          out  1      one-cycle pulse at the end of a load
//   words_loaded  out  CNT_W  words written in the current/last load

module ins_mem_loader
  import ins_mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          CNT_W     = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len_words,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic [31:0]       IAddr,
  output logic [WORD_W-1:0] IDataIn,
  output logic              InsMemRW,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_loaded
);

  loader_state_t     state, next_state;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  words_next;
  logic [WORD_W-1:0] packed_word;
  logic [WORD_W-1:0] last_word;
  logic              word_full;
  logic              shift_en;
  logic              load_go;

  assign load_go    = (state == ST_IDLE) && start;
  assign shift_en   = byte_valid && byte_ready;
  assign words_next = words_loaded + CNT_W'(1);

  ins_word_packer u_packer (
    .clk       (CLK),
    .rst       (Reset),
    .clear     (load_go),
    .shift_en  (shift_en),
    .byte_in   (byte_data),
    .word      (packed_word),
    .word_full (word_full)
  );

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic. WRITE always lasts one cycle; a zero-length start
  // goes straight to DONE so the host still sees a completion pulse.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) next_state = (len_words != '0) ? ST_RECV : ST_DONE;
      end
      ST_RECV: begin
        if (word_full) next_state = ST_WRITE;
      end
      ST_WRITE: begin
        next_state = (words_next == len_q) ? ST_DONE : ST_RECV;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs depend on state only, so byte_ready has no path back from the
  // packer's word_full and the handshake stays loop-free.
  assign byte_ready = (state == ST_RECV);
  assign InsMemRW   = (state == ST_WRITE) ? MEM_WR : MEM_RD;
  assign busy       = (state == ST_RECV) || (state == ST_WRITE);
  assign done       = (state == ST_DONE);
  assign IDataIn    = (state == ST_WRITE) ? packed_word : last_word;

  // Load length, address and word counters. last_word keeps the previous
  // instruction on IDataIn while the packer is filling the next one.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      len_q        <= '0;
      words_loaded <= '0;
      IAddr        <= BASE_ADDR;
      last_word    <= '0;
    end else if (load_go) begin
      len_q        <= len_words;
      words_loaded <= '0;
      IAddr        <= BASE_ADDR;
    end else if (state == ST_WRITE) begin
      words_loaded <= words_next;
      IAddr        <= IAddr + 32'd4;
      last_word    <= packed_word;
    end
  end

endmodule

// File: tb/tb_ins_mem_loader.sv
// tb_ins_mem_loader
//   Directed bench for ins_mem_loader. Expected writes are queued when the
//   bytes of a word are driven and popped by a monitor whenever InsMemRW
//   goes low. A bench-side memory array captures every write so a full
//   load can be read back word by word.

module tb_ins_mem_loader;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        start;
  logic [7:0]  len_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] IAddr;
  logic [31:0] IDataIn;
  logic        InsMemRW;
  logic        busy;
  logic        done;
  logic [7:0]  words_loaded;

  ins_mem_loader #(.BASE_ADDR(32'h0), .CNT_W(8)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .start        (start),
    .len_words    (len_words),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .IAddr        (IAddr),
    .IDataIn      (IDataIn),
    .InsMemRW     (InsMemRW),
    .busy         (busy),
    .done         (done),
    .words_loaded (words_loaded)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expq[$];
  wr_t         monExp;
  int          total = 0;
  int          bad = 0;
  int          doneCount = 0;
  int          writeCount = 0;
  logic        prevRw = 1'b1;
  logic [31:0] nextAddr;
  logic [31:0] mem    [0:127];
  logic [31:0] golden [0:127];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic failNow(input string tag);
    total++;
    bad++;
    $error("[TB] FAIL %s got=timeout exp=event", tag);
  endtask

  // Monitor: every write strobe must be a single cycle, must not overlap
  // byte_ready, and must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (Reset === 1'b0) begin
      if (done === 1'b1) doneCount++;
      if (InsMemRW === 1'b0) begin
        writeCount++;
        checkOutput("rw_single_cycle", 32'(prevRw), 32'd1);
        checkOutput("ready_low_in_write", 32'(byte_ready), 32'd0);
        total++;
        assert (expq.size() != 0) else begin
          bad++;
          $error("[TB] FAIL unexpected_write got=%h exp=none", IAddr);
        end
        if (expq.size() != 0) begin
          monExp = expq.pop_front();
          checkOutput("write_addr", IAddr, monExp.addr);
          checkOutput("write_data", IDataIn, monExp.data);
        end
        if (IAddr < 32'd512) mem[IAddr[8:2]] = IDataIn;
      end
    end
    prevRw = InsMemRW;
  end

  task automatic sendByte(input logic [7:0] b, input int gap);
    int budget;
    byte_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge CLK);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    budget     = 0;
    @(negedge CLK);
    while (byte_ready !== 1'b1 && budget < 50) begin
      @(negedge CLK);
      budget++;
    end
    if (byte_ready !== 1'b1) failNow("byte_ready_timeout");
    @(posedge CLK);
    #1;
    byte_valid = 1'b0;
  endtask

  // Queue the expected write, then drive the word's four bytes MSB first
  task automatic applyStimulus(input logic [31:0] w, input int maxGap);
    expq.push_back({nextAddr, w});
    nextAddr = nextAddr + 32'd4;
    for (int k = 0; k < 4; k++)
      sendByte(w[31-8*k -: 8], (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0);
  endtask

  task automatic startLoad(input logic [7:0] len);
    start     = 1'b1;
    len_words = len;
    @(posedge CLK);
    #1;
    start     = 1'b0;
    len_words = 8'hA5;
    nextAddr  = 32'h0;
  endtask

  task automatic waitDone(input string tag);
    int budget;
    budget = 0;
    @(negedge CLK);
    while (done !== 1'b1 && budget < 2000) begin
      @(negedge CLK);
      budget++;
    end
    if (done !== 1'b1) failNow(tag);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rw"},    32'(InsMemRW),     32'd1);
    checkOutput({tag, "_addr"},  IAddr,             32'h0);
    checkOutput({tag, "_data"},  IDataIn,           32'h0);
    checkOutput({tag, "_ready"}, 32'(byte_ready),   32'd0);
    checkOutput({tag, "_busy"},  32'(busy),         32'd0);
    checkOutput({tag, "_done"},  32'(done),         32'd0);
    checkOutput({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    int d0;
    int w0;
    Reset      = 1'b1;
    start      = 1'b0;
    len_words  = 8'd0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    nextAddr   = 32'h0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;

    // Reset state
    #1;
    checkResetOutputs("reset");
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    @(posedge CLK);
    #1;

    // 1) single word, back-to-back bytes
    $display("[TB] single word load");
    d0 = doneCount;
    w0 = writeCount;
    startLoad(8'd1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    applyStimulus(32'h20010005, 0);
    @(negedge CLK);
    checkOutput("t1_rw",    32'(InsMemRW),   32'd0);
    checkOutput("t1_addr",  IAddr,           32'h0);
    checkOutput("t1_data",  IDataIn,         32'h20010005);
    checkOutput("t1_ready", 32'(byte_ready), 32'd0);
    @(negedge CLK);
    checkOutput("t1_done",  32'(done),         32'd1);
    checkOutput("t1_busy0", 32'(busy),         32'd0);
    checkOutput("t1_words", 32'(words_loaded), 32'd1);
    @(posedge CLK);
    #1;
    checkOutput("t1_done_count", 32'(doneCount - d0), 32'd1);
    checkOutput("t1_hold_data",  IDataIn,             32'h20010005);

    // 2) three words with random valid gaps
    $display("[TB] three words with gaps");
    d0 = doneCount;
    w0 = writeCount;
    startLoad(8'd3);
    applyStimulus(32'hDEADBEEF, 3);
    applyStimulus(32'h00000013, 3);
    applyStimulus(32'hFFFFFFFF, 3);
    waitDone("t2_done_timeout");
    checkOutput("t2_words", 32'(words_loaded), 32'd3);
    @(posedge CLK);
    #1;
    checkOutput("t2_done_count",  32'(doneCount - d0),  32'd1);
    checkOutput("t2_write_count", 32'(writeCount - w0), 32'd3);
    checkOutput("t2_queue_empty", 32'(expq.size()),     32'd0);

    // 3) zero-length load
    $display("[TB] zero length load");
    d0 = doneCount;
    w0 = writeCount;
    startLoad(8'd0);
    @(negedge CLK);
    checkOutput("t3_done", 32'(done),     32'd1);
    checkOutput("t3_rw",   32'(InsMemRW), 32'd1);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checkOutput("t3_done_low",    32'(done),              32'd0);
    checkOutput("t3_done_count",  32'(doneCount - d0),    32'd1);
    checkOutput("t3_write_count", 32'(writeCount - w0),   32'd0);
    @(posedge CLK);
    #1;

    // 4) reset in the middle of a 4-word load
    $display("[TB] reset mid load");
    w0 = writeCount;
    startLoad(8'd4);
    applyStimulus(32'h11223344, 0);
    applyStimulus(32'h55667788, 0);
    sendByte(8'h99, 0);
    sendByte(8'hAA, 0);
    checkOutput("t4_addr_before", IAddr,                32'h8);
    checkOutput("t4_words_before", 32'(words_loaded),   32'd2);
    #2;
    Reset = 1'b1;
    #1;
    checkResetOutputs("t4_async");
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    checkOutput("t4_write_count", 32'(writeCount - w0), 32'd2);
    checkOutput("t4_queue_empty", 32'(expq.size()),     32'd0);
    startLoad(8'd1);
    applyStimulus(32'hCAFEF00D, 1);
    waitDone("t4_done_timeout");
    checkOutput("t4_words_after", 32'(words_loaded), 32'd1);
    @(posedge CLK);
    #1;

    // 5) start pulse with a different length during RECV is ignored
    $display("[TB] start ignored while busy");
    d0 = doneCount;
    w0 = writeCount;
    startLoad(8'd3);
    sendByte(8'h01, 0);
    start     = 1'b1;
    len_words = 8'd1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    expq.push_back({nextAddr, 32'h01020304});
    nextAddr = nextAddr + 32'd4;
    sendByte(8'h02, 0);
    sendByte(8'h03, 0);
    sendByte(8'h04, 0);
    applyStimulus(32'h0BADC0DE, 1);
    applyStimulus(32'h12345678, 1);
    waitDone("t5_done_timeout");
    checkOutput("t5_words", 32'(words_loaded), 32'd3);
    @(posedge CLK);
    #1;
    checkOutput("t5_done_count",  32'(doneCount - d0),  32'd1);
    checkOutput("t5_write_count", 32'(writeCount - w0), 32'd3);

    // 6) fill the whole memory and read it back
    $display("[TB] full 128 word load");
    for (int i = 0; i < 128; i++) golden[i] = $urandom;
    startLoad(8'd128);
    for (int i = 0; i < 128; i++) applyStimulus(golden[i], 0);
    waitDone("t6_done_timeout");
    checkOutput("t6_words", 32'(words_loaded), 32'd128);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 128; i++) checkOutput($sformatf("t6_readback_%0d", i), mem[i], golden[i]);
    checkOutput("t6_queue_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
